paint_draw_sched: RTL

- Sequencer and arbiter for the paint canvas fill datapath.
- Accepts rectangle-fill commands from two requesters: the user brush/square tool (port 0) and the clear-canvas path (port 1).
- Normalises and clamps the corner pair, then scans the rectangle one pixel per accepted cycle into the VGA adapter plot port.
- The only block allowed to drive the adapter's plot inputs.

---
 rtl/paint_draw_sched.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/paint_draw_sched.sv
// paint_draw_sched: round-robin arbiter and rectangle scan sequencer.
// It takes fill commands from the square tool (port 0) and the clear path
// (port 1), then walks the clamped rectangle one pixel per accepted cycle
// into the VGA adapter plot port.
module paint_draw_sched #(
    parameter int         CANVAS_W  = 160,
    parameter int         CANVAS_H  = 120,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic [7:0] x0_a,
    input  logic [7:0] y0_a,
    input  logic [7:0] x0_b,
    input  logic [7:0] y0_b,
    input  logic [2:0] colour0,
    output logic       ack0,
    input  logic       req1,
    output logic       ack1,
    output logic       plot_valid,
    input  logic       plot_ready,
    output logic [7:0] plot_x,
    output logic [7:0] plot_y,
    output logic [2:0] plot_colour,
    output logic       busy,
    output logic       done,
    output logic       grant_id
);

    localparam logic [7:0] X_LAST = 8'(CANVAS_W - 1);
    localparam logic [7:0] Y_LAST = 8'(CANVAS_H - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DRAW = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0] state_q, state_d;
    logic       rr_last_q, rr_last_d;   // port granted most recently
    logic       gid_q, gid_d;
    logic [7:0] xa_q, xa_d, ya_q, ya_d, xb_q, xb_d, yb_q, yb_d;
    logic [2:0] col_q, col_d;
    logic [7:0] xmin_q, xmin_d, xmax_q, xmax_d, ymax_q, ymax_d;
    logic [7:0] x_q, x_d, y_q, y_d;

    logic       grant0, grant1;
    logic [7:0] lx_min, lx_max, ly_min, ly_max;
    logic       empty;

    // Arbitration: on a tie the port not granted last wins; acks only in IDLE.
    always_comb begin
        grant0 = req0 && (!req1 || rr_last_q);
        grant1 = req1 && (!req0 || !rr_last_q);
        ack0   = (state_q == S_IDLE) && !reset && grant0;
        ack1   = (state_q == S_IDLE) && !reset && grant1;
    end

    // Normalise the captured corners, clamp the far edge, flag off-canvas commands.
    always_comb begin
        lx_min = (xa_q < xb_q) ? xa_q : xb_q;
        lx_max = (xa_q < xb_q) ? xb_q : xa_q;
        ly_min = (ya_q < yb_q) ? ya_q : yb_q;
        ly_max = (ya_q < yb_q) ? yb_q : ya_q;
        if (lx_max > X_LAST) lx_max = X_LAST;
        if (ly_max > Y_LAST) ly_max = Y_LAST;
        empty = (lx_min > X_LAST) || (ly_min > Y_LAST);
    end

    // Next-state logic for the FSM, command capture and the scan position.
    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        rr_last_d = rr_last_q;
        gid_d     = gid_q;
        xa_d      = xa_q;
        ya_d      = ya_q;
        xb_d      = xb_q;
        yb_d      = yb_q;
        col_d     = col_q;
        xmin_d    = xmin_q;
        xmax_d    = xmax_q;
        ymax_d    = ymax_q;
        x_d       = x_q;
        y_d       = y_q;
        case (state_q)
            S_IDLE: begin
                if (ack0) begin
                    xa_d = x0_a;  ya_d = y0_a;
                    xb_d = x0_b;  yb_d = y0_b;
                    col_d     = colour0;
                    gid_d     = 1'b0;
                    rr_last_d = 1'b0;
                    state_d   = S_LOAD;
                end else if (ack1) begin
                    xa_d = 8'd0;    ya_d = 8'd0;
                    xb_d = X_LAST;  yb_d = Y_LAST;
                    col_d     = BG_COLOUR;
                    gid_d     = 1'b1;
                    rr_last_d = 1'b1;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                xmin_d  = lx_min;
                xmax_d  = lx_max;
                ymax_d  = ly_max;
                x_d     = lx_min;
                y_d     = ly_min;
                state_d = empty ? S_DONE : S_DRAW;
            end
            S_DRAW: begin
                if (plot_ready) begin
                    // Edges found by equality so a 255 coordinate never wraps.
                    if (x_q == xmax_q) begin
                        if (y_q == ymax_q) begin
                            state_d = S_DONE;
                        end else begin
                            x_d = xmin_q;
                            y_d = y_q + 8'd1;
                        end
                    end else begin
                        x_d = x_q + 8'd1;
                    end
                end
            end
            default: state_d = S_IDLE;   // S_DONE lasts exactly one cycle
        endcase
    end

    // State registers with synchronous reset; an abort drops the command silently.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state_q   <= S_IDLE;
            rr_last_q <= 1'b1;       // port 0 wins the first tie
            gid_q     <= 1'b0;
            xa_q      <= 8'd0;
            ya_q      <= 8'd0;
            xb_q      <= 8'd0;
            yb_q      <= 8'd0;
            col_q     <= 3'd0;
            xmin_q    <= 8'd0;
            xmax_q    <= 8'd0;
            ymax_q    <= 8'd0;
            x_q       <= 8'd0;
            y_q       <= 8'd0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            gid_q     <= gid_d;
            xa_q      <= xa_d;
            ya_q      <= ya_d;
            xb_q      <= xb_d;
            yb_q      <= yb_d;
            col_q     <= col_d;
            xmin_q    <= xmin_d;
            xmax_q    <= xmax_d;
            ymax_q    <= ymax_d;
            x_q       <= x_d;
            y_q       <= y_d;
        end
    end

    // Status and plot port are straight decodes of registered state.
    always_comb begin
        plot_valid  = (state_q == S_DRAW);
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE);
        plot_x      = x_q;
        plot_y      = y_q;
        plot_colour = col_q;
        grant_id    = gid_q;
    end

endmodule
